// File: rtl/kernel_pr_start_fifo_param.sv
// kernel_pr_start_fifo_param
// Parametrised start/handshake FIFO for kernel_pr dataflow processes, built on
// a shift-register store. Adds an occupancy count, programmable almost-full /
// almost-empty flags, non-power-of-two depth and a synchronous flush.
//
// Optional feature: define KERNEL_PR_FIFO_ERR_FLAGS_EN to add sticky
// overflow_err / underflow_err outputs.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   if_din, if_write,
//   if_write_ce, if_full_n  write side handshake
//   if_dout, if_read,
//   if_read_ce, if_empty_n  read side handshake (if_dout is combinational)
//   flush                   synchronous clear of occupancy
//   if_count                occupancy 0..DEPTH
//   if_almost_full          registered, count >= AFULL_THRESH
//   if_almost_empty         registered, count <= AEMPTY_THRESH
//   overflow_err,
//   underflow_err           sticky error flags (KERNEL_PR_FIFO_ERR_FLAGS_EN only)
module kernel_pr_start_fifo_param #(
  parameter int unsigned DATA_WIDTH    = 1,
  parameter int unsigned ADDR_WIDTH    = 2,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned AFULL_THRESH  = 3,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full,
`ifdef KERNEL_PR_FIFO_ERR_FLAGS_EN
  output logic                  if_almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
`else
  output logic                  if_almost_empty
`endif
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CW-1:0]         count_nxt;

  assign wr_acc = if_write & if_write_ce & if_full_n;
  assign rd_acc = if_read  & if_read_ce  & if_empty_n;

  // Shift-register store: newest token at index 0, oldest at count-1.
  // Shifts on every accepted write, flush or not.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      srl[0] <= if_din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  // Oldest-token read mux; falls back to srl[0] when empty.
  always_comb begin
    if_dout = srl[0];
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (if_count == CW'(i + 1)) begin
        if_dout = srl[i];
      end
    end
  end

  // Next occupancy; flush has priority over any handshake.
  always_comb begin
    count_nxt = if_count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = if_count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = if_count - CW'(1);
    end
  end

  // Count and flags share one edge so they can never disagree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_count        <= '0;
      if_empty_n      <= 1'b0;
      if_full_n       <= 1'b1;
      if_almost_full  <= 1'b0;
      if_almost_empty <= 1'b1;
    end else begin
      if_count        <= count_nxt;
      if_empty_n      <= (count_nxt != '0);
      if_full_n       <= (count_nxt != DEPTH_C);
      if_almost_full  <= (count_nxt >= AFULL_C);
      if_almost_empty <= (count_nxt <= AEMPTY_C);
    end
  end

`ifdef KERNEL_PR_FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = if_write & if_write_ce & ~if_full_n;
  assign unf_set = if_read  & if_read_ce  & ~if_empty_n;

  // Sticky error flags; flush clears and wins over a same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= overflow_err  | ovf_set;
      underflow_err <= underflow_err | unf_set;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_pr_start_fifo_param.sv
// Self-checking bench for kernel_pr_start_fifo_param: two instances (DEPTH=4
// with 1-bit data, DEPTH=3 with 8-bit data) share one stimulus stream and are
// each compared against a token-queue reference model.
module tb_kernel_pr_start_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       write, write_ce, read, read_ce, flush;

  logic       u0_full_n, u0_empty_n, u0_af, u0_ae, u0_dout;
  logic [2:0] u0_cnt;
  logic       u1_full_n, u1_empty_n, u1_af, u1_ae;
  logic [7:0] u1_dout;
  logic [2:0] u1_cnt;
  logic       u0_ovf, u0_unf, u1_ovf, u1_unf;

  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, an ordered token list (index 0 = oldest).
  logic [7:0] mq   [2][8];
  int         mc   [2];
  logic       movf [2];
  logic       munf [2];
  int         dep  [2] = '{4, 3};
  int         afth [2] = '{3, 2};
  int         aeth [2] = '{1, 0};

  always #5 clk = ~clk;

  kernel_pr_start_fifo_param #(
    .DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .if_din(din[0]), .if_write(write),
    .if_write_ce(write_ce), .if_full_n(u0_full_n), .if_dout(u0_dout),
    .if_read(read), .if_read_ce(read_ce), .if_empty_n(u0_empty_n),
    .flush(flush), .if_count(u0_cnt), .if_almost_full(u0_af),
`ifdef KERNEL_PR_FIFO_ERR_FLAGS_EN
    .if_almost_empty(u0_ae), .overflow_err(u0_ovf), .underflow_err(u0_unf)
`else
    .if_almost_empty(u0_ae)
`endif
  );

  kernel_pr_start_fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(3), .AFULL_THRESH(2), .AEMPTY_THRESH(0)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .if_din(din), .if_write(write),
    .if_write_ce(write_ce), .if_full_n(u1_full_n), .if_dout(u1_dout),
    .if_read(read), .if_read_ce(read_ce), .if_empty_n(u1_empty_n),
    .flush(flush), .if_count(u1_cnt), .if_almost_full(u1_af),
`ifdef KERNEL_PR_FIFO_ERR_FLAGS_EN
    .if_almost_empty(u1_ae), .overflow_err(u1_ovf), .underflow_err(u1_unf)
`else
    .if_almost_empty(u1_ae)
`endif
  );

`ifndef KERNEL_PR_FIFO_ERR_FLAGS_EN
  assign u0_ovf = 1'b0;
  assign u0_unf = 1'b0;
  assign u1_ovf = 1'b0;
  assign u1_unf = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare one instance against the model, then advance the model by the
  // edge that follows (inputs are stable from posedge+1 to the next posedge).
  task automatic inst(input int k, input logic [7:0] dout, input logic [2:0] cnt,
                      input logic fn, input logic en, input logic af, input logic ae,
                      input logic ovf, input logic unf);
    string p;
    logic  wr, rd;
    logic [7:0] d;
    p = (k == 0) ? "u0" : "u1";
    if (!reset_n) begin
      mc[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
    end
    chk({p, "_count"},   32'(cnt), 32'(mc[k]));
    chk({p, "_empty_n"}, 32'(en),  32'(mc[k] != 0));
    chk({p, "_full_n"},  32'(fn),  32'(mc[k] != dep[k]));
    chk({p, "_afull"},   32'(af),  32'(mc[k] >= afth[k]));
    chk({p, "_aempty"},  32'(ae),  32'(mc[k] <= aeth[k]));
`ifdef KERNEL_PR_FIFO_ERR_FLAGS_EN
    chk({p, "_overflow_err"},  32'(ovf), 32'(movf[k]));
    chk({p, "_underflow_err"}, 32'(unf), 32'(munf[k]));
`else
    if (ovf || unf) chk({p, "_err_absent"}, 32'({ovf, unf}), 32'(0));
`endif
    if (!reset_n) return;
    wr = write && write_ce && (mc[k] < dep[k]);
    rd = read && read_ce && (mc[k] > 0);
    // Scoreboard pop on an accepted read: the head token must be presented.
    if (rd) chk({p, "_rd_data"}, 32'(dout), 32'(mq[k][0]));
    if (write && write_ce && (mc[k] == dep[k])) movf[k] = 1'b1;
    if (read && read_ce && (mc[k] == 0))        munf[k] = 1'b1;
    if (flush) begin
      mc[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
    end else begin
      if (rd) begin
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        mc[k]--;
      end
      if (wr) begin
        d = (k == 0) ? {7'b0, din[0]} : din;
        mq[k][mc[k]] = d;
        mc[k]++;
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      inst(0, {7'b0, u0_dout}, u0_cnt, u0_full_n, u0_empty_n, u0_af, u0_ae, u0_ovf, u0_unf);
      inst(1, u1_dout, u1_cnt, u1_full_n, u1_empty_n, u1_af, u1_ae, u1_ovf, u1_unf);
    end
  end

  task automatic cyc(input logic w, input logic wce, input logic r, input logic rce,
                     input logic f, input logic [7:0] d);
    write = w; write_ce = wce; read = r; read_ce = rce; flush = f; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    write = 1'b0; write_ce = 1'b0; read = 1'b0; read_ce = 1'b0; flush = 1'b0; din = '0;
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill: u0 reaches full at 4, u1 reaches full at 3 and overflows on the 4th.
    cyc(1, 1, 0, 1, 0, 8'hA1);
    cyc(1, 1, 0, 1, 0, 8'h5E);
    cyc(1, 1, 0, 1, 0, 8'h33);
    cyc(1, 1, 0, 1, 0, 8'hC7);
    cyc(0, 1, 0, 1, 0, 8'h00);
    // Full with read+write: only the read is taken.
    cyc(1, 1, 1, 1, 0, 8'hF0);
    cyc(0, 1, 0, 1, 0, 8'h00);
    // Drain, plus one read on empty.
    repeat (4) cyc(0, 1, 1, 1, 0, 8'h00);
    // Two tokens, then five cycles of simultaneous read+write.
    cyc(1, 1, 0, 1, 0, 8'h12);
    cyc(1, 1, 0, 1, 0, 8'h35);
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0, 8'($urandom));
    // Third token, then flush together with a write.
    cyc(1, 1, 0, 1, 0, 8'h6B);
    cyc(1, 1, 0, 1, 1, 8'h9D);
    cyc(0, 1, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 1, 0, 8'h00);

    // Randomised traffic with phases biased toward full and toward empty.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w, r, wce, rce, f;
        w   = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30));
        r   = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75));
        wce = ($urandom_range(0, 9) != 0);
        rce = ($urandom_range(0, 9) != 0);
        f   = ($urandom_range(0, 39) == 0);
        cyc(w, wce, r, rce, f, 8'($urandom));
      end
    end

    // Reset dropped mid-burst, between clock edges.
    cyc(1, 1, 0, 1, 0, 8'h44);
    cyc(1, 1, 0, 1, 0, 8'h55);
    #1 reset_n = 1'b0;
    #1;
    chk("u0_rst_count",   32'(u0_cnt),     32'(0));
    chk("u0_rst_empty_n", 32'(u0_empty_n), 32'(0));
    chk("u0_rst_full_n",  32'(u0_full_n),  32'(1));
    chk("u1_rst_count",   32'(u1_cnt),     32'(0));
    chk("u1_rst_full_n",  32'(u1_full_n),  32'(1));
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cyc(1, 1, 0, 1, 0, 8'($urandom));
    repeat (4) cyc(0, 1, 1, 1, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
